// File: rtl/kd_tree_traverse_pipe_pkg.sv
// Shared types for the kd-tree traversal pipeline: node record, FSM states
// and the helper that sizes the split-dimension field.
package kd_pkg;

   // Node fields are sized for the widest supported configuration so the
   // record type stays independent of the instance parameters; writes
   // zero-extend into it.
   localparam int NODE_SEL_MAX = 8;
   localparam int NODE_THR_MAX = 32;

   typedef struct packed {
      logic [NODE_SEL_MAX-1:0] split_dim;
      logic [NODE_THR_MAX-1:0] threshold;
   } node_t;

   typedef enum logic [1:0] {
      ST_LOAD  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   // Width of the split_dim field: max(1, clog2(patch_dim)).
   function automatic int sel_width(input int patch_dim);
      return (patch_dim <= 2) ? 1 : $clog2(patch_dim);
   endfunction

endpackage

// File: rtl/kd_tree_traverse_pipe_if.sv
// Bus bundle for the traversal pipeline: node configuration, query input
// stream, result output stream and a state observation signal.
//
// Handshake rule for both streams: a transfer happens on a rising clock edge
// where valid and ready are both 1. The source keeps valid and its payload
// stable until that edge; ready may depend combinationally on the sink state.
interface kd_tree_traverse_pipe_if
   import kd_pkg::*;
#(
   parameter int DEPTH      = 6,
   parameter int PATCH_DIM  = 5,
   parameter int COMP_WIDTH = 11,
   parameter int TAG_WIDTH  = 8
);
   localparam int SEL_W = sel_width(PATCH_DIM);

   logic                            cfg_valid;
   logic [SEL_W+COMP_WIDTH-1:0]     cfg_data;
   logic                            cfg_clear;
   logic                            cfg_done;
   logic                            in_valid;
   logic                            in_ready;
   logic [PATCH_DIM*COMP_WIDTH-1:0] in_patch;
   logic [TAG_WIDTH-1:0]            in_tag;
   logic                            out_valid;
   logic                            out_ready;
   logic [DEPTH-1:0]                out_leaf;
   logic [TAG_WIDTH-1:0]            out_tag;
   state_t                          state;

   modport master (
      output cfg_valid, cfg_data, cfg_clear, in_valid, in_patch, in_tag, out_ready,
      input  cfg_done, in_ready, out_valid, out_leaf, out_tag, state
   );

   modport slave (
      input  cfg_valid, cfg_data, cfg_clear, in_valid, in_patch, in_tag, out_ready,
      output cfg_done, in_ready, out_valid, out_leaf, out_tag, state
   );

endinterface

// File: rtl/kd_tree_traverse_pipe_level_stage.sv
// One tree level: pick this level's node from the accumulated path, select
// the split component, compare against the threshold and register the
// extended path together with tag and valid. Holds everything on stall.
module kd_level_stage
   import kd_pkg::*;
#(
   parameter int LEVEL      = 0,
   parameter int DEPTH      = 6,
   parameter int PATCH_DIM  = 5,
   parameter int COMP_WIDTH = 11,
   parameter int TAG_WIDTH  = 8
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            hold,
   input  node_t                           nodes [2**DEPTH-1],
   input  logic                            in_valid,
   input  logic [DEPTH-1:0]                in_path,
   input  logic [PATCH_DIM*COMP_WIDTH-1:0] in_patch,
   input  logic [TAG_WIDTH-1:0]            in_tag,
   output logic                            out_valid,
   output logic [DEPTH-1:0]                out_path,
   output logic [TAG_WIDTH-1:0]            out_tag
);
   // First node of this level in breadth-first order.
   localparam logic [DEPTH-1:0] BASE = DEPTH'((2**LEVEL) - 1);

   node_t                 node;
   logic [COMP_WIDTH-1:0] comp;
   logic                  go_right;

   // Node select, component mux (out-of-range split_dim falls back to 0)
   // and unsigned compare; ties branch right.
   always_comb begin
      node = nodes[BASE + in_path];
      comp = in_patch[COMP_WIDTH-1:0];
      for (int k = 1; k < PATCH_DIM; k++) begin
         if (int'(node.split_dim) == k) comp = in_patch[k*COMP_WIDTH +: COMP_WIDTH];
      end
      go_right = NODE_THR_MAX'(comp) >= node.threshold;
   end

   // Level register: append the branch bit as the new path LSB.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_path  <= '0;
         out_tag   <= '0;
      end else if (!hold) begin
         out_valid <= in_valid;
         out_path  <= (in_path << 1) | DEPTH'(go_right);
         out_tag   <= in_tag;
      end
   end

endmodule

// File: rtl/kd_tree_traverse_pipe.sv
// kd-tree traversal pipeline: nodes are loaded breadth-first, then queries
// walk DEPTH registered levels, one per cycle, producing a leaf index.
// A clear request drains in-flight queries before the tree is reloaded.
module kd_tree_traverse_pipe
   import kd_pkg::*;
#(
   parameter int DEPTH      = 6,
   parameter int PATCH_DIM  = 5,
   parameter int COMP_WIDTH = 11,
   parameter int TAG_WIDTH  = 8
) (
   input logic                    clk,
   input logic                    rst_n,
   kd_tree_traverse_pipe_if.slave bus
);
   localparam int SEL_W = sel_width(PATCH_DIM);
   localparam int NODES = 2**DEPTH - 1;
   localparam int PW    = PATCH_DIM * COMP_WIDTH;
   localparam logic [DEPTH-1:0] LAST_ADR  = DEPTH'(NODES - 1);
   localparam logic [DEPTH-1:0] LAST_MASK = DEPTH'(1) << (DEPTH - 1);

   state_t           state_q;
   logic [DEPTH-1:0] wadr;
   logic             cfg_done_q;
   node_t            nodes [NODES];
   node_t            wnode;

   logic [DEPTH-1:0]     vld_q;
   logic [DEPTH-1:0]     path_q  [DEPTH];
   logic [TAG_WIDTH-1:0] tag_q   [DEPTH];
   logic [PW-1:0]        patch_q [DEPTH-1];
   logic                 stage_vld   [DEPTH];
   logic [DEPTH-1:0]     stage_path  [DEPTH];
   logic [TAG_WIDTH-1:0] stage_tag   [DEPTH];
   logic [PW-1:0]        stage_patch [DEPTH];

   logic stall, in_ready, accept, in_flight, drain_done;

   assign stall      = vld_q[DEPTH-1] & ~bus.out_ready;
   assign in_ready   = (state_q == ST_RUN) & ~stall;
   // A clear in the same cycle wins over an offered query.
   assign accept     = bus.in_valid & in_ready & ~bus.cfg_clear;
   assign in_flight  = |vld_q;
   // Only the output stage may still hold a result, and it leaves now.
   assign drain_done = ((vld_q & ~LAST_MASK) == '0) & (~vld_q[DEPTH-1] | bus.out_ready);

   assign wnode.split_dim = NODE_SEL_MAX'(bus.cfg_data[SEL_W+COMP_WIDTH-1:COMP_WIDTH]);
   assign wnode.threshold = NODE_THR_MAX'(bus.cfg_data[COMP_WIDTH-1:0]);

   assign bus.cfg_done  = cfg_done_q;
   assign bus.in_ready  = in_ready;
   assign bus.out_valid = vld_q[DEPTH-1];
   assign bus.out_leaf  = path_q[DEPTH-1];
   assign bus.out_tag   = tag_q[DEPTH-1];
   assign bus.state     = state_q;

   // Control FSM with node storage: LOAD fills nodes, RUN accepts queries,
   // DRAIN lets in-flight queries finish on the old tree.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_LOAD;
         wadr       <= '0;
         cfg_done_q <= 1'b0;
         for (int i = 0; i < NODES; i++) nodes[i] <= '0;
      end else begin
         case (state_q)
            ST_LOAD: begin
               if (bus.cfg_clear) begin
                  wadr <= '0;
               end else if (bus.cfg_valid) begin
                  nodes[wadr] <= wnode;
                  wadr        <= wadr + DEPTH'(1);
                  if (wadr == LAST_ADR) begin
                     state_q    <= ST_RUN;
                     cfg_done_q <= 1'b1;
                  end
               end
            end
            ST_RUN: begin
               if (bus.cfg_clear) begin
                  cfg_done_q <= 1'b0;
                  wadr       <= '0;
                  state_q    <= in_flight ? ST_DRAIN : ST_LOAD;
               end
            end
            ST_DRAIN: begin
               if (drain_done) begin
                  state_q <= ST_LOAD;
                  wadr    <= '0;
               end
            end
            default: state_q <= ST_LOAD;
         endcase
      end
   end

   // Patch copies travel alongside the path so each level sees its query.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH-1; i++) patch_q[i] <= '0;
      end else if (!stall) begin
         for (int i = 0; i < DEPTH-1; i++) patch_q[i] <= stage_patch[i];
      end
   end

   for (genvar l = 0; l < DEPTH; l++) begin : g_level
      if (l == 0) begin : g_first
         assign stage_vld[l]   = accept;
         assign stage_path[l]  = '0;
         assign stage_tag[l]   = bus.in_tag;
         assign stage_patch[l] = bus.in_patch;
      end else begin : g_rest
         assign stage_vld[l]   = vld_q[l-1];
         assign stage_path[l]  = path_q[l-1];
         assign stage_tag[l]   = tag_q[l-1];
         assign stage_patch[l] = patch_q[l-1];
      end

      kd_level_stage #(
         .LEVEL      (l),
         .DEPTH      (DEPTH),
         .PATCH_DIM  (PATCH_DIM),
         .COMP_WIDTH (COMP_WIDTH),
         .TAG_WIDTH  (TAG_WIDTH)
      ) u_stage (
         .clk       (clk),
         .rst_n     (rst_n),
         .hold      (stall),
         .nodes     (nodes),
         .in_valid  (stage_vld[l]),
         .in_path   (stage_path[l]),
         .in_patch  (stage_patch[l]),
         .in_tag    (stage_tag[l]),
         .out_valid (vld_q[l]),
         .out_path  (path_q[l]),
         .out_tag   (tag_q[l])
      );
   end

endmodule

// File: tb/tb_kd_tree_traverse_pipe.sv
// Bench for kd_tree_traverse_pipe: directed vector table on a uniform tree,
// random queries on random trees checked against a tree-walk model,
// backpressure, drain/reload and reset-in-flight sequences.
module tb_kd_tree_traverse_pipe;
   import kd_pkg::*;

   localparam int DEPTH     = 6;
   localparam int PATCH_DIM = 5;
   localparam int CW        = 11;
   localparam int TW        = 8;
   localparam int NODES     = 2**DEPTH - 1;
   localparam int PW        = PATCH_DIM * CW;

   typedef struct {
      logic [PW-1:0]    patch;
      logic [TW-1:0]    tag;
      logic [DEPTH-1:0] leaf;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   kd_tree_traverse_pipe_if #(.DEPTH(DEPTH), .PATCH_DIM(PATCH_DIM), .COMP_WIDTH(CW), .TAG_WIDTH(TW)) bus ();

   kd_tree_traverse_pipe #(.DEPTH(DEPTH), .PATCH_DIM(PATCH_DIM), .COMP_WIDTH(CW), .TAG_WIDTH(TW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // clock / cycle counter
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int errors = 0;
   int checks = 0;
   logic [DEPTH+TW-1:0] exp_q[$];
   bit mon_en = 1'b0;
   int rcv_cnt = 0;
   int first_cyc = 0;
   int last_cyc = 0;

   // reference tree: breadth-first node table
   int         m_sd  [NODES];
   logic [CW-1:0] m_thr [NODES];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Walk the tree from the root using child = 2n+1+branch.
   function automatic logic [DEPTH-1:0] ref_leaf(input logic [PW-1:0] p);
      int n = 0;
      int d;
      logic [CW-1:0] c;
      for (int l = 0; l < DEPTH; l++) begin
         d = (m_sd[n] >= PATCH_DIM) ? 0 : m_sd[n];
         c = p[d*CW +: CW];
         n = 2*n + 1 + ((c >= m_thr[n]) ? 1 : 0);
      end
      return DEPTH'(n - NODES);
   endfunction

   function automatic logic [PW-1:0] rand_patch();
      logic [PW-1:0] p;
      for (int k = 0; k < PATCH_DIM; k++) p[k*CW +: CW] = CW'($urandom_range(0, 2047));
      return p;
   endfunction

   function automatic vec_t mk_vec(input int c0, input int tg, input int lf);
      vec_t v;
      v.patch = rand_patch();
      v.patch[CW-1:0] = CW'(c0);
      v.tag = TW'(tg);
      v.leaf = DEPTH'(lf);
      return v;
   endfunction

   // scoreboard: every output handshake must match the oldest expectation
   always @(negedge clk) begin
      if (rst_n && mon_en && bus.out_valid && bus.out_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_result", 32'({bus.out_leaf, bus.out_tag}), 32'h0);
            errors += 0;
         end else begin
            check("result", 32'({bus.out_leaf, bus.out_tag}), 32'(exp_q.pop_front()));
         end
         if (rcv_cnt == 0) first_cyc = cyc;
         last_cyc = cyc;
         rcv_cnt++;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Load all nodes; mode 0: uniform {0,1024}, mode 1: random.
   task automatic load_tree(input int mode);
      int sd;
      int thr;
      for (int i = 0; i < NODES; i++) begin
         sd  = (mode == 0) ? 0 : int'($urandom_range(0, 7));
         thr = (mode == 0) ? 1024 : int'($urandom_range(256, 1791));
         m_sd[i]  = sd;
         m_thr[i] = CW'(thr);
         bus.cfg_valid = 1'b1;
         bus.cfg_data  = {3'(sd), CW'(thr)};
         if (i == NODES - 1) begin
            @(negedge clk);
            check("cfg_done_before_last", 32'(bus.cfg_done), 0);
            check("in_ready_during_load", 32'(bus.in_ready), 0);
         end
         tick();
      end
      bus.cfg_valid = 1'b0;
      @(negedge clk);
      check("cfg_done_after_load", 32'(bus.cfg_done), 1);
      check("state_run_after_load", 32'(bus.state), 32'(ST_RUN));
      check("in_ready_after_load", 32'(bus.in_ready), 1);
      tick();
   endtask

   // Offer one query and wait (bounded) for acceptance.
   task automatic send(input logic [PW-1:0] p, input logic [TW-1:0] t);
      int w = 0;
      bus.in_valid = 1'b1;
      bus.in_patch = p;
      bus.in_tag   = t;
      @(negedge clk);
      while (!bus.in_ready && w < 200) begin
         w++;
         @(negedge clk);
      end
      if (!bus.in_ready) check("accept_timeout", 32'(bus.in_ready), 1);
      else exp_q.push_back({ref_leaf(p), t});
      tick();
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_empty(input int budget);
      int w = 0;
      while (exp_q.size() != 0 && w < budget) begin
         @(negedge clk);
         w++;
      end
      check("queue_drained", 32'(exp_q.size()), 0);
      tick();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs[4];
      int lat;
      logic [DEPTH-1:0] hold_leaf;
      logic [TW-1:0] hold_tag;

      vecs[0] = mk_vec(1024, 8'h11, 6'h3F);
      vecs[1] = mk_vec(1023, 8'h22, 6'h00);
      vecs[2] = mk_vec(2047, 8'h33, 6'h3F);
      vecs[3] = mk_vec(0,    8'h44, 6'h00);

      bus.cfg_valid = 1'b0;
      bus.cfg_data  = '0;
      bus.cfg_clear = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_patch  = '0;
      bus.in_tag    = '0;
      bus.out_ready = 1'b0;

      // reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", 32'(bus.out_valid), 0);
      check("rst_cfg_done", 32'(bus.cfg_done), 0);
      check("rst_in_ready", 32'(bus.in_ready), 0);
      check("rst_out_leaf", 32'(bus.out_leaf), 0);
      check("rst_out_tag", 32'(bus.out_tag), 0);
      check("rst_state", 32'(bus.state), 32'(ST_LOAD));
      rst_n = 1'b1;
      tick();
      bus.out_ready = 1'b1;

      // directed table on the uniform tree, with latency
      load_tree(0);
      for (int i = 0; i < 4; i++) begin
         send(vecs[i].patch, vecs[i].tag);
         lat = 0;
         do begin
            @(negedge clk);
            lat++;
         end while (!bus.out_valid && lat < 20);
         check("latency", 32'(lat), 6);
         check("vec_leaf", 32'(bus.out_leaf), 32'(vecs[i].leaf));
         check("vec_tag", 32'(bus.out_tag), 32'(vecs[i].tag));
         tick();
      end
      exp_q.delete();
      mon_en = 1'b1;

      // clear with empty pipe goes straight to LOAD
      bus.cfg_clear = 1'b1;
      tick();
      bus.cfg_clear = 1'b0;
      @(negedge clk);
      check("clear_empty_state", 32'(bus.state), 32'(ST_LOAD));
      check("clear_empty_done", 32'(bus.cfg_done), 0);
      tick();
      load_tree(1);

      // streaming
      rcv_cnt = 0;
      for (int i = 0; i < 64; i++) send(rand_patch(), TW'(i));
      wait_empty(100);
      check("stream_count", 32'(rcv_cnt), 64);
      check("stream_span", 32'(last_cyc - first_cyc), 63);

      // backpressure with a full pipe
      bus.out_ready = 1'b0;
      rcv_cnt = 0;
      for (int i = 0; i < 6; i++) send(rand_patch(), TW'(8'hA0 + i));
      @(negedge clk);
      check("bp_out_valid", 32'(bus.out_valid), 1);
      check("bp_front_leaf", 32'(bus.out_leaf), 32'(exp_q[0][DEPTH+TW-1:TW]));
      hold_leaf = bus.out_leaf;
      hold_tag  = bus.out_tag;
      repeat (5) begin
         @(negedge clk);
         check("bp_in_ready", 32'(bus.in_ready), 0);
         check("bp_leaf_stable", 32'(bus.out_leaf), 32'(hold_leaf));
         check("bp_tag_stable", 32'(bus.out_tag), 32'(hold_tag));
      end
      tick();
      bus.out_ready = 1'b1;
      wait_empty(50);
      check("bp_count", 32'(rcv_cnt), 6);

      // reload with three queries in flight
      for (int i = 0; i < 3; i++) send(rand_patch(), TW'(8'hC0 + i));
      bus.cfg_clear = 1'b1;
      tick();
      bus.cfg_clear = 1'b0;
      bus.cfg_valid = 1'b1;
      bus.cfg_data  = '1;
      @(negedge clk);
      check("drain_state", 32'(bus.state), 32'(ST_DRAIN));
      check("drain_in_ready", 32'(bus.in_ready), 0);
      check("drain_cfg_done", 32'(bus.cfg_done), 0);
      tick();
      tick();
      bus.cfg_valid = 1'b0;
      wait_empty(50);
      @(negedge clk);
      check("after_drain_state", 32'(bus.state), 32'(ST_LOAD));
      tick();
      load_tree(1);
      for (int i = 0; i < 20; i++) send(rand_patch(), TW'($urandom_range(0, 255)));
      wait_empty(50);

      // reset while the pipe is full
      bus.out_ready = 1'b0;
      for (int i = 0; i < 6; i++) send(rand_patch(), TW'(8'hE0 + i));
      rst_n = 1'b0;
      #1;
      check("midrst_out_valid", 32'(bus.out_valid), 0);
      check("midrst_cfg_done", 32'(bus.cfg_done), 0);
      check("midrst_state", 32'(bus.state), 32'(ST_LOAD));
      exp_q.delete();
      tick();
      rst_n = 1'b1;
      bus.out_ready = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("postrst_in_ready", 32'(bus.in_ready), 0);
         check("postrst_out_valid", 32'(bus.out_valid), 0);
      end
      tick();
      load_tree(1);
      for (int i = 0; i < 10; i++) send(rand_patch(), TW'($urandom_range(0, 255)));
      wait_empty(50);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
